// File: rtl/sr_cpu_step_ctrl_if.sv
// Command, breakpoint and status bundle between the key-command logic and sr_cpu_step_ctrl.
// The master side issues commands and supplies the PC; the slave side returns the step pulse and status.
interface sr_cpu_step_ctrl_if #(
    parameter int unsigned w_addr = 32
);
    logic              cmd_run;
    logic              cmd_halt;
    logic              cmd_step;
    logic              bp_en;
    logic [w_addr-1:0] bp_addr;
    logic [w_addr-1:0] pc;
    logic              cpu_en;
    logic              running;
    logic              bp_hit;
    logic [31:0]       step_count;

    modport master (
        output cmd_run, cmd_halt, cmd_step, bp_en, bp_addr, pc,
        input  cpu_en, running, bp_hit, step_count
    );

    modport slave (
        input  cmd_run, cmd_halt, cmd_step, bp_en, bp_addr, pc,
        output cpu_en, running, bp_hit, step_count
    );
endinterface

// File: rtl/sr_cpu_step_ctrl.sv
// Run/halt/single-step clock-enable sequencer for sr_cpu.
// Define SR_STEP_CTRL_BREAKPOINT_EN to build the PC breakpoint (BREAK state, bp_hit).
module sr_cpu_step_ctrl #(
    parameter int unsigned clk_mhz = 50,
    parameter int unsigned run_hz  = 2,
    parameter int unsigned run_div = clk_mhz * 1_000_000 / run_hz,
    parameter int unsigned w_addr  = 32
) (
    input logic              clk,
    input logic              rst,
    sr_cpu_step_ctrl_if.slave ctl
);
    localparam int unsigned div_w = $clog2(run_div);
    localparam logic [div_w-1:0] div_last = div_w'(run_div - 1);

    typedef enum logic [1:0] {HALT, RUN, STEP, BREAK} state_t;

    state_t           state;
    logic [div_w-1:0] div;
    logic             first;
    logic             cpu_en_q;
    logic             running_q;
    logic             bp_hit_q;
    logic [31:0]      step_count_q;
    logic             bp_match;
    logic             fire;

`ifdef SR_STEP_CTRL_BREAKPOINT_EN
    logic [w_addr-1:0] pc_cur;
    logic [w_addr-1:0] bp_cur;
    assign pc_cur   = ctl.pc;
    assign bp_cur   = ctl.bp_addr;
    assign bp_match = ctl.bp_en && (pc_cur == bp_cur) && !first;
`else
    logic [w_addr-1:0] unused_bp;
    assign unused_bp = ctl.pc ^ ctl.bp_addr ^ {w_addr{ctl.bp_en | first}};
    assign bp_match  = 1'b0;
`endif

    assign fire = (div == div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HALT;
            div          <= '0;
            first        <= 1'b0;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            bp_hit_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            cpu_en_q     <= 1'b0;
            step_count_q <= step_count_q + {31'd0, cpu_en_q};
            unique case (state)
                HALT, BREAK: begin
                    if (ctl.cmd_halt) begin
                        state <= state;
                    end else if (ctl.cmd_step) begin
                        state    <= STEP;
                        cpu_en_q <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end else if (ctl.cmd_run) begin
                        // The command cycle counts as divider phase 0, so the
                        // registered pulse lands exactly run_div cycles later.
                        state     <= RUN;
                        running_q <= 1'b1;
                        div       <= div_w'(1);
                        first     <= 1'b1;
                        bp_hit_q  <= 1'b0;
                    end
                end
                STEP: begin
                    if (ctl.cmd_run && !ctl.cmd_halt && !ctl.cmd_step) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                        div       <= div_w'(1);
                        first     <= 1'b1;
                    end else begin
                        state <= HALT;
                    end
                end
                RUN: begin
                    if (ctl.cmd_halt) begin
                        state     <= HALT;
                        running_q <= 1'b0;
                        div       <= '0;
                    end else begin
                        div <= fire ? '0 : div + div_w'(1);
                        if (fire) begin
                            if (bp_match) begin
                                state     <= BREAK;
                                running_q <= 1'b0;
                                bp_hit_q  <= 1'b1;
                            end else begin
                                cpu_en_q <= 1'b1;
                                first    <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign ctl.cpu_en     = cpu_en_q;
    assign ctl.running    = running_q;
    assign ctl.bp_hit     = bp_hit_q;
    assign ctl.step_count = step_count_q;
endmodule

// File: tb/tb_sr_cpu_step_ctrl.sv
// Bench for sr_cpu_step_ctrl: directed scenarios plus random commands against a timeline model.
// The model tracks run start cycles and pulse phases arithmetically, with a looping 8-instruction core PC.
module tb_sr_cpu_step_ctrl;
    localparam int unsigned run_div = 4;
`ifdef SR_STEP_CTRL_BREAKPOINT_EN
    localparam bit bp_impl = 1'b1;
`else
    localparam bit bp_impl = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_cpu_step_ctrl_if #(.w_addr(32)) bus ();

    sr_cpu_step_ctrl #(
        .clk_mhz(50),
        .run_hz (2),
        .run_div(run_div),
        .w_addr (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    // Reference model: what the outputs should be in the current cycle.
    bit          m_run, m_step, m_en, m_hit, m_first;
    int          m_start;
    logic [31:0] m_cnt;
    logic [31:0] core_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("cpu_en", {31'd0, bus.cpu_en}, {31'd0, m_en});
        check("running", {31'd0, bus.running}, {31'd0, m_run});
        check("bp_hit", {31'd0, bus.bp_hit}, {31'd0, m_hit});
        check("step_count", bus.step_count, m_cnt);
    endtask

    task automatic model_clear();
        m_run = 0; m_step = 0; m_en = 0; m_hit = 0; m_first = 0;
        m_start = 0; m_cnt = '0; core_pc = '0;
    endtask

    // Drive one cycle of commands, advance the model across the edge, check after it.
    task automatic tick(input bit r, input bit h, input bit s);
        bit n_en, fire, bp_stop;
        bus.cmd_run = r; bus.cmd_halt = h; bus.cmd_step = s; bus.pc = core_pc;
        n_en    = 0;
        fire    = m_run && ((cyc - m_start) % run_div == run_div - 1);
        bp_stop = bp_impl && bus.bp_en && (core_pc == bus.bp_addr) && !m_first;
        if (m_step) begin
            m_step = 0;
            if (r && !h && !s) begin m_run = 1; m_start = cyc; m_first = 1; end
        end else if (m_run) begin
            if (h) m_run = 0;
            else if (fire) begin
                if (bp_stop) begin m_run = 0; m_hit = 1; end
                else begin n_en = 1; m_first = 0; end
            end
        end else if (!h) begin
            if (s) begin m_step = 1; n_en = 1; m_hit = 0; end
            else if (r) begin m_run = 1; m_start = cyc; m_first = 1; m_hit = 0; end
        end
        if (m_en) begin
            m_cnt   = m_cnt + 1;
            core_pc = (core_pc + 32'd4) & 32'h1F;
        end
        m_en = n_en;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset();
        bus.cmd_run = 0; bus.cmd_halt = 0; bus.cmd_step = 0;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        check_outputs();
    endtask

    initial begin
        bus.cmd_run = 0; bus.cmd_halt = 0; bus.cmd_step = 0;
        bus.bp_en = 0; bus.bp_addr = '0; bus.pc = '0;
        model_clear();
        async_reset();

        // Single step in cycle 10.
        idle(10);
        tick(0, 0, 1);
        idle(3);
        check("step_done_count", bus.step_count, 32'd1);

        // Run for three pulses, halt after the third.
        tick(1, 0, 0);
        idle(12);
        tick(0, 1, 0);
        idle(5);
        check("run_halt_count", bus.step_count, 32'd4);

        // Breakpoint at 0x8, then resume from it.
        async_reset();
        bus.bp_en = 1; bus.bp_addr = 32'h8;
        tick(1, 0, 0);
        idle(14);
        check("bp_stop_hit", {31'd0, bus.bp_hit}, {31'd0, bp_impl});
        tick(1, 0, 0);
        idle(6);
        check("bp_resume_hit", {31'd0, bus.bp_hit}, 32'd0);
        tick(0, 1, 0);
        bus.bp_en = 0;
        idle(2);

        // Halt and step together in HALT; halt landing on the fire cycle.
        tick(0, 1, 1);
        idle(2);
        tick(1, 0, 0);
        idle(2);
        tick(0, 1, 0);
        idle(4);

        // Asynchronous reset in the middle of RUN.
        tick(1, 0, 0);
        idle(5);
        async_reset();
        idle(6);

        // Random command traffic with changing breakpoints.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.bp_en   = $urandom_range(0, 1) == 1;
                bus.bp_addr = 32'($urandom_range(0, 7)) << 2;
            end
            if ($urandom_range(0, 599) == 0) async_reset();
            else tick($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
